// File: rtl/systolic_pkg.sv
// Shared types and constants for the 4x4 weight-stationary systolic array sequencer.
package systolic_pkg;

    localparam int ARRAY_W = 4;
    localparam int CNT_W   = 16;
    localparam int ROW_W   = $clog2(ARRAY_W);

    typedef logic [2:0] col_size_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_WLOAD,
        S_SWITCH,
        S_FEED,
        S_DRAIN,
        S_FIN
    } ctrl_state_t;

    // One bit per enabled column, lowest columns first.
    function automatic logic [ARRAY_W-1:0] col_mask(input col_size_t cols);
        logic [ARRAY_W-1:0] m;
        m = '0;
        for (int i = 0; i < ARRAY_W; i++) begin
            m[i] = (i < int'(cols));
        end
        return m;
    endfunction

    // Legal column counts are 1..ARRAY_W.
    function automatic logic col_size_ok(input col_size_t cols);
        return (cols != 3'd0) && (int'(cols) <= ARRAY_W);
    endfunction

endpackage

// File: rtl/systolic_wload_seq.sv
// Weight-load sequencer: issues ARRAY_W weight row reads (bottom row first) and
// raises accept_w on the enabled columns one cycle later, aligned with the
// returned buffer data. Runs for ARRAY_W+1 cycles after a start pulse.
module systolic_wload_seq
    import systolic_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         col_size,
    output logic               w_rd_en,
    output logic [ROW_W-1:0]   w_rd_row,
    output logic [ARRAY_W-1:0] accept_w,
    output logic               done
);

    localparam int K_W = $clog2(ARRAY_W + 1);
    localparam logic [K_W-1:0] K_LAST      = K_W'(ARRAY_W);
    localparam logic [K_W-1:0] K_LAST_READ = K_W'(ARRAY_W - 1);

    logic           active;
    logic [K_W-1:0] k;

    // Final cycle of the sequence; the main FSM moves on at the next edge.
    assign done = active && (k == K_LAST);

    // Step k through 0..ARRAY_W, reads lead the accept strobes by one cycle.
    always_ff @(posedge clk) begin
        // NOTE: all state here is sequential, so every assignment is non-blocking;
        // blocking writes would make later reads in this block see new values.
        if (rst) begin
            active   <= 1'b0;
            k        <= '0;
            w_rd_en  <= 1'b0;
            w_rd_row <= '0;
            accept_w <= '0;
        end else if (start) begin
            active   <= 1'b1;
            k        <= '0;
            w_rd_en  <= 1'b1;
            w_rd_row <= ROW_W'(ARRAY_W - 1);
            accept_w <= '0;
        end else if (active) begin
            if (k == K_LAST) begin
                active   <= 1'b0;
                k        <= '0;
                w_rd_en  <= 1'b0;
                w_rd_row <= '0;
                accept_w <= '0;
            end else begin
                k        <= k + K_W'(1);
                accept_w <= col_mask(col_size);
                if (k < K_LAST_READ) begin
                    w_rd_en  <= 1'b1;
                    w_rd_row <= w_rd_row - ROW_W'(1);
                end else begin
                    w_rd_en  <= 1'b0;
                    w_rd_row <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Matmul command sequencer for the weight-stationary systolic array:
// configure columns, load weights, switch, feed input vectors, then count
// bottom-row valids (with an idle timeout) before reporting completion.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CNT_W-1:0]   cmd_num_vec,
    input  logic [2:0]         cmd_col_size,
    output logic [15:0]        ub_rd_col_size_out,
    output logic               ub_rd_col_size_valid_out,
    output logic               w_rd_en,
    output logic [ROW_W-1:0]   w_rd_row,
    output logic [ARRAY_W-1:0] sys_accept_w,
    output logic               sys_switch_out,
    output logic               x_rd_en,
    output logic [CNT_W-1:0]   x_rd_idx,
    output logic               sys_start_out,
    input  logic [ARRAY_W-1:0] sys_valid_in,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_TIMEOUT - 1);

    ctrl_state_t      state;
    logic [CNT_W-1:0] num_vec_q;
    logic [2:0]       col_q;
    logic [CNT_W-1:0] vcnt;
    logic [IDLE_W-1:0] idle_cnt;

    logic             wload_start;
    logic             wload_done;
    logic [ROW_W-1:0] col_idx;
    logic             valid_hit;
    logic [CNT_W-1:0] vcnt_next;

    assign wload_start = (state == S_CFG);

    // Only the last enabled column's bottom-row valid is counted, and only from
    // FEED onward; the count saturates at the requested vector count.
    assign col_idx   = ROW_W'(col_q - 3'd1);
    assign valid_hit = ((state == S_FEED) || (state == S_DRAIN))
                       && sys_valid_in[col_idx] && (vcnt != num_vec_q);
    assign vcnt_next = valid_hit ? vcnt + CNT_W'(1) : vcnt;

    systolic_wload_seq u_wload (
        .clk      (clk),
        .rst      (rst),
        .start    (wload_start),
        .col_size (col_q),
        .w_rd_en  (w_rd_en),
        .w_rd_row (w_rd_row),
        .accept_w (sys_accept_w),
        .done     (wload_done)
    );

    // Main sequencer; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                    <= S_IDLE;
            num_vec_q                <= '0;
            col_q                    <= '0;
            vcnt                     <= '0;
            idle_cnt                 <= '0;
            cmd_ready                <= 1'b1;
            busy                     <= 1'b0;
            ub_rd_col_size_out       <= '0;
            ub_rd_col_size_valid_out <= 1'b0;
            sys_switch_out           <= 1'b0;
            x_rd_en                  <= 1'b0;
            x_rd_idx                 <= '0;
            sys_start_out            <= 1'b0;
            done                     <= 1'b0;
            err                      <= 1'b0;
        end else begin
            ub_rd_col_size_valid_out <= 1'b0;
            sys_switch_out           <= 1'b0;
            done                     <= 1'b0;
            err                      <= 1'b0;
            // The array sees each input vector one cycle after its read request.
            sys_start_out            <= x_rd_en;
            vcnt                     <= vcnt_next;

            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        num_vec_q <= cmd_num_vec;
                        col_q     <= cmd_col_size;
                        vcnt      <= '0;
                        idle_cnt  <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (col_size_ok(cmd_col_size)) begin
                            state                    <= S_CFG;
                            ub_rd_col_size_valid_out <= 1'b1;
                            ub_rd_col_size_out       <= {13'd0, cmd_col_size};
                        end else begin
                            state <= S_FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                S_CFG: begin
                    state <= S_WLOAD;
                end
                S_WLOAD: begin
                    if (wload_done) begin
                        state          <= S_SWITCH;
                        sys_switch_out <= 1'b1;
                    end
                end
                S_SWITCH: begin
                    if (num_vec_q != '0) begin
                        state    <= S_FEED;
                        x_rd_en  <= 1'b1;
                        x_rd_idx <= '0;
                    end else begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end
                end
                S_FEED: begin
                    // The timeout window opens at the last read, so DRAIN starts one cycle in.
                    idle_cnt <= IDLE_W'(1);
                    if (x_rd_idx == num_vec_q - CNT_W'(1)) begin
                        state    <= S_DRAIN;
                        x_rd_en  <= 1'b0;
                        x_rd_idx <= '0;
                    end else begin
                        x_rd_idx <= x_rd_idx + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Completion wins over a coincident timeout.
                    if (vcnt_next == num_vec_q) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end else if (!valid_hit && (idle_cnt == IDLE_LAST)) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        idle_cnt <= valid_hit ? IDLE_W'(1) : idle_cnt + IDLE_W'(1);
                    end
                end
                S_FIN: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: the driver predicts every output event of a
// command (cycle and value) from the command and its planned valid pattern, and an
// independent monitor matches the events the DUT actually presents.
module tb_systolic_ctrl;
    import systolic_pkg::*;

    localparam int TO       = 64;
    localparam int PLAN_LEN = 256;

    localparam int K_CFG   = 0;
    localparam int K_WRD   = 1;
    localparam int K_ACC   = 2;
    localparam int K_SW    = 3;
    localparam int K_XRD   = 4;
    localparam int K_START = 5;
    localparam int K_DONE  = 6;
    localparam int K_ERR   = 7;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [CNT_W-1:0]   cmd_num_vec = '0;
    logic [2:0]         cmd_col_size = '0;
    logic [15:0]        ub_rd_col_size_out;
    logic               ub_rd_col_size_valid_out;
    logic               w_rd_en;
    logic [ROW_W-1:0]   w_rd_row;
    logic [ARRAY_W-1:0] sys_accept_w;
    logic               sys_switch_out;
    logic               x_rd_en;
    logic [CNT_W-1:0]   x_rd_idx;
    logic               sys_start_out;
    logic [ARRAY_W-1:0] sys_valid_in = '0;
    logic               busy;
    logic               done;
    logic               err;

    systolic_ctrl #(.DRAIN_TIMEOUT(TO)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .cmd_valid                (cmd_valid),
        .cmd_ready                (cmd_ready),
        .cmd_num_vec              (cmd_num_vec),
        .cmd_col_size             (cmd_col_size),
        .ub_rd_col_size_out       (ub_rd_col_size_out),
        .ub_rd_col_size_valid_out (ub_rd_col_size_valid_out),
        .w_rd_en                  (w_rd_en),
        .w_rd_row                 (w_rd_row),
        .sys_accept_w             (sys_accept_w),
        .sys_switch_out           (sys_switch_out),
        .x_rd_en                  (x_rd_en),
        .x_rd_idx                 (x_rd_idx),
        .sys_start_out            (sys_start_out),
        .sys_valid_in             (sys_valid_in),
        .busy                     (busy),
        .done                     (done),
        .err                      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t        exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] vplan [PLAN_LEN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_obs(input int kind, input int val);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got kind=%0d val=%0d at cycle %0d, expected no event",
                     kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != val) begin
                n_fail++;
                $display("FAIL sb_event: got kind=%0d cyc=%0d val=%0d, expected kind=%0d cyc=%0d val=%0d",
                         kind, cyc, val, e.kind, e.cyc, e.val);
            end
        end
    endtask

    // Monitor: every asserted output becomes an event matched against the scoreboard.
    always @(negedge clk) begin
        if (ub_rd_col_size_valid_out === 1'b1) sb_obs(K_CFG, int'(ub_rd_col_size_out));
        if (w_rd_en === 1'b1)                  sb_obs(K_WRD, int'(w_rd_row));
        if (sys_accept_w !== '0)               sb_obs(K_ACC, int'(sys_accept_w));
        if (sys_switch_out === 1'b1)           sb_obs(K_SW, 0);
        if (x_rd_en === 1'b1)                  sb_obs(K_XRD, int'(x_rd_idx));
        if (sys_start_out === 1'b1)            sb_obs(K_START, 0);
        if (done === 1'b1)                     sb_obs(K_DONE, int'(err));
        else if (err === 1'b1)                 sb_obs(K_ERR, 1);
    end

    task automatic push_ev(input int kind, input int c, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic clear_plan();
        for (int i = 0; i < PLAN_LEN; i++) vplan[i] = 4'd0;
    endtask

    // Reference: offsets are cycles after accept. Reads start at offset 7; the
    // command ends once num_vec valids on column col are seen (not before the last
    // read has been issued), or DRAIN_TIMEOUT cycles after the later of the last
    // counted valid and the last read.
    function automatic void model_done(input int n, input int col,
                                       output int done_off, output int err_o);
        int cnt;
        int last;
        int d;
        int ref_c;
        logic [3:0] v;
        done_off = -1;
        err_o    = 0;
        if (col < 1 || col > ARRAY_W) begin
            done_off = 0;
            err_o    = 1;
            return;
        end
        if (n == 0) begin
            done_off = 7;
            return;
        end
        d    = 7 + n;
        cnt  = 0;
        last = -1;
        for (int c = 7; c < PLAN_LEN; c++) begin
            v = vplan[c];
            if (v[col-1] && cnt < n) begin
                cnt++;
                last = c;
            end
            if (c >= d) begin
                if (cnt == n) begin
                    done_off = c + 1;
                    return;
                end
                ref_c = (last > d - 1) ? last : d - 1;
                if (c == ref_c + TO - 1) begin
                    done_off = c + 1;
                    err_o    = 1;
                    return;
                end
            end
        end
    endfunction

    task automatic push_events(input int a, input int n, input int col, input int done_off,
                               input int err_o, input int last_off);
        bit good;
        int mask;
        good = (col >= 1 && col <= ARRAY_W);
        mask = (1 << col) - 1;
        for (int o = 0; o <= last_off; o++) begin
            if (good) begin
                if (o == 0)               push_ev(K_CFG, a + o, col);
                if (o >= 1 && o <= 4)     push_ev(K_WRD, a + o, 4 - o);
                if (o >= 2 && o <= 5)     push_ev(K_ACC, a + o, mask);
                if (o == 6)               push_ev(K_SW, a + o, 0);
                if (o >= 7 && o < 7 + n)  push_ev(K_XRD, a + o, o - 7);
                if (o >= 8 && o <= 7 + n) push_ev(K_START, a + o, 0);
            end
            if (o == done_off) push_ev(K_DONE, a + o, err_o);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_cfg_valid"}, ub_rd_col_size_valid_out, 0);
        check({tag, "_cfg_val"}, ub_rd_col_size_out, 0);
        check({tag, "_w_rd_en"}, w_rd_en, 0);
        check({tag, "_w_rd_row"}, w_rd_row, 0);
        check({tag, "_accept_w"}, sys_accept_w, 0);
        check({tag, "_switch"}, sys_switch_out, 0);
        check({tag, "_x_rd_en"}, x_rd_en, 0);
        check({tag, "_x_rd_idx"}, x_rd_idx, 0);
        check({tag, "_start"}, sys_start_out, 0);
    endtask

    // Issue one command, drive its valid plan, and check busy/cmd_ready each cycle.
    // abort_off >= 0 asserts rst in that cycle (offset from accept).
    task automatic run_cmd(input int n, input int col, input int abort_off);
        int a;
        int done_off;
        int err_o;
        int last_off;
        int waited;
        bit exp_busy;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        model_done(n, col, done_off, err_o);
        last_off = (abort_off >= 0) ? abort_off : done_off;
        a = cyc + 1;
        push_events(a, n, col, done_off, err_o, last_off);
        cmd_valid    = 1'b1;
        cmd_num_vec  = CNT_W'(n);
        cmd_col_size = 3'(col);
        for (int o = 0; o <= last_off + 1; o++) begin
            @(negedge clk);
            cmd_valid    = 1'b0;
            cmd_num_vec  = CNT_W'($urandom);
            cmd_col_size = 3'($urandom);
            sys_valid_in = (o <= last_off && o < PLAN_LEN) ? vplan[o] : 4'd0;
            if (abort_off < 0) begin
                exp_busy = (o <= done_off);
                check("busy", busy, exp_busy);
                check("cmd_ready", cmd_ready, !exp_busy);
            end else if (o == abort_off) begin
                rst = 1'b1;
            end else if (o == abort_off + 1) begin
                check_idle_outputs("abort");
                rst = 1'b0;
            end
        end
        sys_valid_in = 4'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int col;
        clear_plan();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Full-width command, valids on column 4 in DRAIN.
        clear_plan();
        vplan[10] = 4'b1000;
        vplan[12] = 4'b1000;
        vplan[14] = 4'b1000;
        run_cmd(3, 4, -1);

        // Two columns: bit 3 pulses are not counted, bit 1 completes.
        clear_plan();
        vplan[9]  = 4'b1000;
        vplan[10] = 4'b1000;
        vplan[11] = 4'b1000;
        vplan[12] = 4'b0010;
        vplan[14] = 4'b0010;
        run_cmd(2, 2, -1);

        // Zero vectors: switch then straight to done.
        clear_plan();
        run_cmd(0, 1, -1);

        // Illegal column counts.
        run_cmd(3, 0, -1);
        run_cmd(3, 5, -1);
        run_cmd(2, 7, -1);

        // Only two of four valids arrive: timeout.
        clear_plan();
        vplan[12] = 4'b0100;
        vplan[20] = 4'b0100;
        run_cmd(4, 3, -1);

        // Reset mid-FEED at x_rd_idx == 1, then a fresh command.
        clear_plan();
        run_cmd(5, 4, 8);
        clear_plan();
        vplan[9] = 4'b1000;
        run_cmd(1, 4, -1);

        // Randomized commands and valid patterns, including pre-FEED noise.
        repeat (24) begin
            clear_plan();
            n   = $urandom_range(0, 6);
            col = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(1, 4);
            for (int o = 0; o < 60; o++) begin
                for (int b = 0; b < ARRAY_W; b++) begin
                    vplan[o][b] = ($urandom_range(0, 9) < 3);
                end
            end
            run_cmd(n, col, -1);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
